// File: rtl/sigmf_grad.sv
// Sigmoid backward-pass gradient: delta = e * y * (1 - y), Q6.10, one shared multiplier over two cycles.
// Define SIGMF_GRAD_ROUND_EN for round-half-up on both post-multiply shifts (default: floor).
module sigmf_grad #(
    parameter int unsigned     WIDTH = 16,
    parameter int unsigned     FRAC  = 10,
    parameter logic [WIDTH-1:0] ONE  = 16'h0400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] e_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] delta_out,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH;

`ifdef SIGMF_GRAD_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]        y_r, e_r, p1_r;
    logic [WIDTH-1:0]        y_c;
    logic signed [WIDTH-1:0] mul_a, mul_b;
    logic signed [PW-1:0]    prod;
    logic [WIDTH-1:0]        mul_res;
    logic                    accept;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = MUL1;
            MUL1: next_state = MUL2;
            MUL2: next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded controls and multiplier operand select
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        accept   = (state == IDLE) && in_valid;
        mul_a    = $signed(e_r);
        mul_b    = $signed(p1_r);
        if (state == MUL1) begin
            mul_a = $signed(y_c);
            mul_b = $signed(ONE - y_c);
        end
    end

    // Clamp y to [0, ONE] so y*(1-y) stays in [0, 0.25]
    always_comb begin
        y_c = y_r;
        if (y_r[WIDTH-1])
            y_c = '0;
        else if ($signed(y_r) > $signed(ONE))
            y_c = ONE;
    end

    assign prod    = mul_a * mul_b;
    assign mul_res = WIDTH'((prod + RND) >>> FRAC);

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r       <= '0;
            e_r       <= '0;
            p1_r      <= '0;
            delta_out <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                y_r <= y_in;
                e_r <= e_in;
            end
            if (state == MUL1)
                p1_r <= mul_res;
            if (state == MUL2) begin
                delta_out <= mul_res;
                out_valid <= 1'b1;
            end
            if (state == DONE && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sigmf_grad.sv
// Directed + random bench for sigmf_grad: scoreboard queue of expected deltas, immediate-assert checks.
module tb_sigmf_grad;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_in;
    logic [15:0] e_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] delta_out;
    logic        busy;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_q[$];

`ifdef SIGMF_GRAD_ROUND_EN
    localparam int RND = 512;
`else
    localparam int RND = 0;
`endif

    sigmf_grad dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .e_in      (e_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .delta_out (delta_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference in plain integer arithmetic
    function automatic logic [15:0] model(input logic [15:0] y, input logic [15:0] e);
        int yc, p1, d;
        yc = int'($signed(y));
        if (yc < 0) yc = 0;
        if (yc > 1024) yc = 1024;
        p1 = (yc * (1024 - yc) + RND) >>> 10;
        d  = (int'($signed(e)) * p1 + RND) >>> 10;
        return 16'(d);
    endfunction

    // One transaction; expected delta pushed at accept, popped when out_valid rises
    task automatic run(input string tag, input logic [15:0] y, input logic [15:0] e,
                       input logic [15:0] exp, input int stall);
        int          lat;
        logic [15:0] want;
        logic [15:0] held;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        y_in      = y;
        e_in      = e;
        out_ready = (stall == 0);
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        y_in     = 16'($urandom);
        e_in     = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_delta"}, 32'(delta_out), 32'(want));
        held = delta_out;
        if (stall > 0) begin
            in_valid = 1'b1;
            y_in     = 16'h0200;
            e_in     = 16'h7000;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_delta"}, 32'(delta_out), 32'(held));
                check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_delta_kept"}, 32'(delta_out), 32'(held));
    endtask

    initial begin
        logic [15:0] ry, re;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        y_in      = '0;
        e_in      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_delta", 32'(delta_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        run("nominal",   16'd512,  16'd1024,  16'd256,   0);
        run("neg_e",     16'd512,  16'hFC00,  16'hFF00,  0);
        run("y_one",     16'd1024, 16'd1000,  16'd0,     0);
        run("y_neg",     16'hFF9C, 16'd1024,  16'd0,     0);
        run("y_big",     16'd2000, 16'd1024,  16'd0,     0);
        run("e_zero",    16'd300,  16'd0,     16'd0,     0);
        run("backpress", 16'd512,  16'd1024,  16'd256,   5);
`ifdef SIGMF_GRAD_ROUND_EN
        run("round_pos", 16'd512,  16'd3,     16'd1,     0);
`else
        run("round_pos", 16'd512,  16'd3,     16'd0,     0);
`endif
        run("round_neg", 16'd512,  16'hFFFD,  16'hFFFF,  0);

        for (int i = 0; i < 6; i++) begin
            ry = 16'($urandom_range(0, 1024));
            re = 16'($urandom_range(0, 16'hFFFF));
            run("random", ry, re, model(ry, re), i % 2);
        end

        // Async reset while the second multiply is pending
        @(negedge clk);
        in_valid = 1'b1;
        y_in     = 16'd512;
        e_in     = 16'd1024;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_delta", 32'(delta_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_stale_valid", 32'(out_valid), 32'd0);
        end
        check("rst_idle_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle_delta", 32'(delta_out), 32'd0);

        run("post_reset", 16'd512, 16'd1024, 16'd256, 0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
